// File: rtl/mem_resp_queue.sv
// mem_resp_queue
//
// MEM-stage response queue. Holds up to DEPTH in-order memory-stage
// operations, captures data_sram_data_ok responses whether or not WB is
// accepting, applies load extension and hands results to WB. On a flush all
// queued entries are dropped and the responses still owed by memory are
// counted so they can be silently discarded when they arrive.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   req_valid/ready    EX -> queue handshake
//   req_wait           operation expects exactly one data_ok
//   req_load           result comes from memory (else req_result)
//   req_type           load type (011/111 w, 001 h, 010 b, 101 hu, 110 bu)
//   req_addr_low2      low address bits for sub-word selection
//   req_result         ALU result for non-load operations
//   req_info           opaque payload carried with the entry
//   data_sram_data_ok  memory response strobe (in request order)
//   data_sram_rdata    memory response data
//   flush              cancel everything queued
//   out_valid/wb_allowin  queue -> WB handshake
//   out_result         extended load data or ALU result
//   out_info           head payload
//   busy               entries queued or discards still pending
//
// Handshake semantics: a transfer happens on a rising clk edge where the
// producer's valid and the consumer's ready (req_ready / wb_allowin) are both
// high. Neither ready depends on the same-side valid. req_ready is computed
// from registered state only, so a dequeue does not free a slot for an
// enqueue in the same cycle.

module mem_resp_queue #(
    parameter int DEPTH  = 4,
    parameter int INFO_W = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wait,
    input  logic              req_load,
    input  logic [2:0]        req_type,
    input  logic [1:0]        req_addr_low2,
    input  logic [31:0]       req_result,
    input  logic [INFO_W-1:0] req_info,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              wb_allowin,
    output logic [31:0]       out_result,
    output logic [INFO_W-1:0] out_info,
    output logic              busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage. Validity is implied by head/count, so the payload
    // arrays need no reset.
    logic              e_wait   [DEPTH];
    logic              e_load   [DEPTH];
    logic [2:0]        e_type   [DEPTH];
    logic [1:0]        e_low2   [DEPTH];
    logic [31:0]       e_result [DEPTH];
    logic [INFO_W-1:0] e_info   [DEPTH];
    logic [31:0]       e_data   [DEPTH];
    logic              e_got    [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] discard_cnt;

    // rsp_ptr: oldest queued entry still owed a response. It is found by
    // scanning from the head, which skips wait=0 entries naturally and is
    // immune to wait=0 entries leaving the queue ahead of it. With nothing
    // owed it rests at the tail (0 after reset/flush).
    logic [PW-1:0] rsp_ptr;
    logic          rsp_found;
    logic [CW-1:0] pend_cnt;
    logic [PW-1:0] scan_idx;

    always_comb begin
        rsp_ptr   = tail;
        rsp_found = 1'b0;
        pend_cnt  = '0;
        scan_idx  = head;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PW'(k);
            if (CW'(k) < count && e_wait[scan_idx] && !e_got[scan_idx]) begin
                pend_cnt = pend_cnt + CW'(1);
                if (!rsp_found) begin
                    rsp_found = 1'b1;
                    rsp_ptr   = scan_idx;
                end
            end
        end
    end

    logic          rsp_take;
    logic          head_ready;
    logic          enq;
    logic          deq;
    logic [CW:0]   occ;
    logic          flush_dec;

    // A response belongs to a live entry only when no stale responses are owed.
    assign rsp_take   = data_sram_data_ok && (discard_cnt == '0) && rsp_found;

    // Same-cycle bypass: if the head is the entry being answered right now it
    // is already deliverable, using data_sram_rdata directly.
    assign head_ready = (count != '0) &&
                        (!e_wait[head] || e_got[head] || (rsp_take && rsp_ptr == head));

    assign occ        = {1'b0, count} + {1'b0, discard_cnt};
    assign req_ready  = !flush && (occ < (CW+1)'(DEPTH));
    assign out_valid  = head_ready && !flush;
    assign enq        = req_valid && req_ready;
    assign deq        = out_valid && wb_allowin;
    assign busy       = (count != '0) || (discard_cnt != '0);

    // In the flush cycle a data_ok consumes one owed response: either an
    // already-discarded one or one of the entries being dropped now. A data_ok
    // with nothing owed at all is a protocol error and is ignored.
    assign flush_dec  = data_sram_data_ok && ((discard_cnt != '0) || (pend_cnt != '0));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            discard_cnt <= '0;
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            discard_cnt <= discard_cnt + pend_cnt - CW'(flush_dec);
        end else begin
            if (enq)
                tail <= tail + PW'(1);
            if (deq)
                head <= head + PW'(1);
            count <= count + CW'(enq) - CW'(deq);
            if (data_sram_data_ok && discard_cnt != '0)
                discard_cnt <= discard_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            e_wait[tail]   <= req_wait;
            e_load[tail]   <= req_load;
            e_type[tail]   <= req_type;
            e_low2[tail]   <= req_addr_low2;
            e_result[tail] <= req_result;
            e_info[tail]   <= req_info;
            e_got[tail]    <= 1'b0;
        end
        // rsp_ptr always names a live entry, never the free tail slot, so
        // this cannot collide with the enqueue write above.
        if (!flush && rsp_take) begin
            e_data[rsp_ptr] <= data_sram_rdata;
            e_got[rsp_ptr]  <= 1'b1;
        end
    end

    // Load extension on the head entry.
    logic [31:0] word;
    logic [15:0] half;
    logic [7:0]  byte_sel;
    logic [31:0] ext;

    always_comb begin
        word = e_got[head] ? e_data[head] : data_sram_rdata;
        half = e_low2[head][1] ? word[31:16] : word[15:0];
        case (e_low2[head])
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        case (e_type[head])
            3'b001:  ext = {{16{half[15]}}, half};
            3'b010:  ext = {{24{byte_sel[7]}}, byte_sel};
            3'b101:  ext = {16'h0, half};
            3'b110:  ext = {24'h0, byte_sel};
            default: ext = word;
        endcase
    end

    assign out_result = e_load[head] ? ext : e_result[head];
    assign out_info   = e_info[head];

endmodule

// File: tb/tb_mem_resp_queue.sv
module tb_mem_resp_queue;

    localparam int DEPTH  = 4;
    localparam int INFO_W = 64;

    logic              clk;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic              req_wait;
    logic              req_load;
    logic [2:0]        req_type;
    logic [1:0]        req_addr_low2;
    logic [31:0]       req_result;
    logic [INFO_W-1:0] req_info;
    logic              data_sram_data_ok;
    logic [31:0]       data_sram_rdata;
    logic              flush;
    logic              out_valid;
    logic              wb_allowin;
    logic [31:0]       out_result;
    logic [INFO_W-1:0] out_info;
    logic              busy;

    mem_resp_queue #(.DEPTH(DEPTH), .INFO_W(INFO_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_wait          (req_wait),
        .req_load          (req_load),
        .req_type          (req_type),
        .req_addr_low2     (req_addr_low2),
        .req_result        (req_result),
        .req_info          (req_info),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush),
        .out_valid         (out_valid),
        .wb_allowin        (wb_allowin),
        .out_result        (out_result),
        .out_info          (out_info),
        .busy              (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0]     exp_q[$];
    logic [INFO_W-1:0] exp_info_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (resetn && out_valid && wb_allowin) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: got result %0h with nothing expected", out_result);
            end else begin
                logic [31:0]       e_res;
                logic [INFO_W-1:0] e_inf;
                e_res = exp_q.pop_front();
                e_inf = exp_info_q.pop_front();
                chk("sb_result", {32'h0, out_result}, {32'h0, e_res});
                chk("sb_info", out_info, e_inf);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic w, input logic ld, input logic [2:0] ty,
                       input logic [1:0] lo, input logic [31:0] res,
                       input logic [63:0] info, input logic [31:0] exp,
                       input bit push);
        int n;
        req_valid     = 1'b1;
        req_wait      = w;
        req_load      = ld;
        req_type      = ty;
        req_addr_low2 = lo;
        req_result    = res;
        req_info      = info;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL enq_timeout: req_ready stayed 0 for %0d cycles", n);
        end else if (push) begin
            exp_q.push_back(exp);
            exp_info_q.push_back(info);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] d);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = d;
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        resetn = 1'b0;
        req_valid = 1'b0; req_wait = 1'b0; req_load = 1'b0; req_type = 3'b011;
        req_addr_low2 = 2'd0; req_result = '0; req_info = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        flush = 1'b0; wb_allowin = 1'b1;

        tick(); tick();
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_busy",      {63'h0, busy},      64'h0);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        resetn = 1'b1;
        tick();

        // ld.b, low2=3, response two cycles after enqueue
        enq(1'b1, 1'b1, 3'b010, 2'd3, 32'h0, 64'h101, 32'hFFFF_FF80, 1'b1);
        chk("ldb_wait", {63'h0, out_valid}, 64'h0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_0000;
        #1;
        chk("ldb_bypass_valid",  {63'h0, out_valid}, 64'h1);
        chk("ldb_bypass_result", {32'h0, out_result}, 64'hFFFF_FF80);
        tick();
        data_sram_data_ok = 1'b0;

        // four ld.w back-to-back while WB stalls
        wb_allowin = 1'b0;
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h201, 32'h11, 1'b1);
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h202, 32'h22, 1'b1);
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h203, 32'h33, 1'b1);
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h204, 32'h44, 1'b1);
        chk("full_req_ready", {63'h0, req_ready}, 64'h0);
        chk("full_no_valid",  {63'h0, out_valid}, 64'h0);
        rsp(32'h11); rsp(32'h22); rsp(32'h33); rsp(32'h44);
        chk("full_count", {61'h0, dut.count}, 64'd4);
        wb_allowin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("deliver_valid", {63'h0, out_valid}, 64'h1);
            tick();
        end
        chk("deliver_done", {63'h0, out_valid}, 64'h0);

        // ld.hu / ALU / ld.hu
        enq(1'b1, 1'b1, 3'b101, 2'd2, 32'h0, 64'h301, 32'h0000_ABCD, 1'b1);
        enq(1'b0, 1'b0, 3'b011, 2'd0, 32'h5, 64'h302, 32'h5, 1'b1);
        enq(1'b1, 1'b1, 3'b101, 2'd2, 32'h0, 64'h303, 32'h0000_ABCD, 1'b1);
        rsp(32'hABCD_0000);
        chk("alu_no_wait_valid",  {63'h0, out_valid}, 64'h1);
        chk("alu_no_wait_result", {32'h0, out_result}, 64'h5);
        tick();
        rsp(32'hABCD_0000);
        chk("mix_empty", {63'h0, busy}, 64'h0);

        // two loads outstanding, flush before any response
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h401, 32'h0, 1'b0);
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h402, 32'h0, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_req_ready", {63'h0, req_ready}, 64'h0);
        tick();
        flush = 1'b0;
        chk("flush_discard2", {61'h0, dut.discard_cnt}, 64'd2);
        chk("flush_busy",     {63'h0, busy}, 64'h1);
        for (int i = 0; i < 2; i++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'hDEAD_0000;
            #1;
            chk("drop_no_valid", {63'h0, out_valid}, 64'h0);
            tick();
            data_sram_data_ok = 1'b0;
        end
        chk("drop_discard0", {61'h0, dut.discard_cnt}, 64'd0);
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h403, 32'h1234_5678, 1'b1);
        rsp(32'h1234_5678);
        tick();

        // flush coincident with data_ok for the first of three pending loads
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h501, 32'h0, 1'b0);
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h502, 32'h0, 1'b0);
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h503, 32'h0, 1'b0);
        flush = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_0001;
        #1;
        chk("flush_ok_no_valid", {63'h0, out_valid}, 64'h0);
        tick();
        flush = 1'b0;
        data_sram_data_ok = 1'b0;
        chk("flush_ok_discard2", {61'h0, dut.discard_cnt}, 64'd2);
        rsp(32'hBAD0_0002);
        rsp(32'hBAD0_0003);
        chk("flush_ok_idle", {63'h0, busy}, 64'h0);

        // asynchronous reset with count=3 and discard_cnt=1
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h601, 32'h0, 1'b0);
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h602, 32'h0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rsp(32'hBAD0_0004);
        enq(1'b0, 1'b0, 3'b011, 2'd0, 32'h7, 64'h603, 32'h0, 1'b0);
        wb_allowin = 1'b0;
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h604, 32'h0, 1'b0);
        enq(1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 64'h605, 32'h0, 1'b0);
        chk("pre_rst_count",   {61'h0, dut.count},       64'd3);
        chk("pre_rst_discard", {61'h0, dut.discard_cnt}, 64'd1);
        chk("pre_rst_valid",   {63'h0, out_valid},       64'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_valid",   {63'h0, out_valid}, 64'h0);
        chk("async_rst_busy",    {63'h0, busy},      64'h0);
        chk("async_rst_ready",   {63'h0, req_ready}, 64'h1);
        chk("async_rst_count",   {61'h0, dut.count}, 64'd0);
        tick();
        resetn = 1'b1;
        wb_allowin = 1'b1;
        tick();

        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            tick();
        chk("sb_drain", {32'h0, 32'(exp_q.size())}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
